// File: rtl/act_buffer_nn.sv
// Ping-pong activation buffer feeding mac_0 a_in_0 of the 2x2 MAC array.
// Optional build macro: ACT_BUF_ZERO_PAD_EN (a_in_0 forced to 0 when rd_en=0).
module act_buffer_nn #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          ctrl_start,
    input  logic          ctrl_busy,
    input  logic          rd_en,
    output logic [DW-1:0] a_in_0,
    output logic [1:0]    bank_full,
    output logic          underrun
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem_q [2][N];
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [IW-1:0] wi_q, wi_d;
    logic [IW-1:0] ri_q, ri_d;
    logic [1:0]    full_q, full_d;
    logic          start_q, start_d;
    logic          underrun_q, underrun_d;

    logic          wr_acc, wr_last;
    logic          rd_ok, rd_last;
    logic [DW-1:0] rd_data;

    assign wr_acc  = wr_en && !full_q[wb_q];
    assign wr_last = wr_acc && (wi_q == LAST);
    assign rd_ok   = rd_en && ((state_q == ARM) || (state_q == STREAM));
    assign rd_last = rd_ok && (ri_q == LAST);

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        wb_d       = wb_q ^ wr_last;
        rb_d       = rb_q ^ rd_last;
        wi_d       = wi_q;
        ri_d       = ri_q;
        full_d     = full_q;
        underrun_d = underrun_q;

        if (wr_acc) begin
            wi_d = wr_last ? '0 : wi_q + 1'b1;
        end
        if (rd_ok) begin
            ri_d = rd_last ? '0 : ri_q + 1'b1;
        end
        // Write and read always target different banks, so both may update.
        if (wr_last) begin
            full_d[wb_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rb_q] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (full_q[rb_q] && !ctrl_busy) begin
                    start_d = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rd_last) begin
                    state_d = DRAIN;
                end else if (ctrl_busy) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (rd_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!ctrl_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_en && ((state_q == IDLE) || (state_q == DRAIN))) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wi_q       <= '0;
            ri_q       <= '0;
            full_q     <= 2'b00;
            start_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wi_q       <= wi_d;
            ri_q       <= ri_d;
            full_q     <= full_d;
            start_q    <= start_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_acc) begin
            mem_q[wb_q][wi_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rb_q][ri_q];

`ifdef ACT_BUF_ZERO_PAD_EN
    assign a_in_0 = rd_en ? rd_data : '0;
`else
    assign a_in_0 = rd_data;
`endif

    assign wr_ready   = !full_q[wb_q];
    assign ctrl_start = start_q;
    assign bank_full  = full_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_act_buffer_nn.sv
// Randomised bench for act_buffer_nn against a count-based reference model.
// The bench also plays the MAC sequencer (busy / rd_en) and the host writer.
module tb_act_buffer_nn;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          ctrl_start;
    logic          ctrl_busy = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] a_in_0;
    logic [1:0]    bank_full;
    logic          underrun;

    always #5 clk = ~clk;

    act_buffer_nn #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy),
        .rd_en(rd_en), .a_in_0(a_in_0),
        .bank_full(bank_full), .underrun(underrun)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: total accepted writes / valid reads define everything.
    logic [DW-1:0] m_bank [2][N];
    int wr_cnt, rd_cnt, mode;
    bit m_und, m_start;

    function automatic int pending();
        return wr_cnt / N - rd_cnt / N;
    endfunction

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) m_bank[b][i] = '0;
        wr_cnt = 0; rd_cnt = 0; mode = 0;
        m_und = 0; m_start = 0;
    endtask

    // Host and sequencer driver state.
    logic [DW-1:0] wq[$];
    logic [DW-1:0] cap[$];
    logic [DW-1:0] exq[$];
    bit nogap = 1, hold = 0, stray_en = 0, force_rd = 0;
    int seq_st = 0, dly = 0, left = 0, tail = 0;

    task automatic compare();
        int pe, rbk, ef, ea;
        pe  = pending();
        rbk = (rd_cnt / N) % 2;
        ef  = 0;
        if (pe >= 1) ef = 1 << rbk;
        if (pe >= 2) ef = 3;
        ea = m_bank[rbk][rd_cnt % N];
`ifdef ACT_BUF_ZERO_PAD_EN
        if (!rd_en) ea = 0;
`endif
        chk("wr_ready", wr_ready, (pe < 2) ? 1 : 0);
        chk("bank_full", bank_full, ef);
        chk("underrun", underrun, m_und);
        chk("ctrl_start", ctrl_start, m_start);
        chk("a_in_0", a_in_0, ea);
    endtask

    task automatic model_update();
        int pe;
        bit acc, rv, st_n;
        pe   = pending();
        acc  = wr_en && (pe < 2);
        rv   = rd_en && (mode == 1);
        st_n = (mode == 0) && (pe >= 1) && !ctrl_busy;
        if (rd_en && mode != 1) m_und = 1;
        if (mode == 0 && st_n) mode = 1;
        else if (mode == 1 && rv && ((rd_cnt + 1) % N == 0)) mode = 2;
        else if (mode == 2 && !ctrl_busy) mode = 0;
        if (acc) begin
            m_bank[(wr_cnt / N) % 2][wr_cnt % N] = wr_data;
            wr_cnt++;
            void'(wq.pop_front());
        end
        if (rv) rd_cnt++;
        m_start = st_n;
    endtask

    task automatic step();
        @(negedge clk);
        wr_en   = (wq.size() > 0) && (nogap || ($urandom % 4 != 0));
        wr_data = (wq.size() > 0) ? wq[0] : DW'($urandom);
        rd_en   = 1'b0;
        if (seq_st == 0 && ctrl_start) begin
            seq_st = 1;
            dly = $urandom % 3;
        end
        if (seq_st == 3) begin
            if (tail == 0) begin
                ctrl_busy = 1'b0;
                seq_st = 0;
            end else tail--;
        end
        if (seq_st == 1) begin
            if (dly == 0) begin
                ctrl_busy = 1'b1;
                seq_st = 2;
                left = N;
            end else dly--;
        end
        if (seq_st == 2) begin
            if (!hold && (nogap || ($urandom % 3 != 0))) begin
                rd_en = 1'b1;
                left--;
                if (left == 0) begin
                    seq_st = 3;
                    tail = $urandom % 3;
                end
            end
        end else if (seq_st == 0) begin
            ctrl_busy = 1'b0;
            rd_en = force_rd || (stray_en && ($urandom % 10 == 0));
        end
        #1;
        compare();
        if (rd_en && mode == 1) cap.push_back(a_in_0);
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_ctrl_start", ctrl_start, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_a_in_0", a_in_0, 0);
        wr_en = 0; rd_en = 0; ctrl_busy = 0;
        m_reset();
        seq_st = 0;
        wq.delete();
        cap.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(string nm);
        int n = 0;
        while (!(wq.size() == 0 && seq_st == 0 && mode == 0 && pending() == 0)
               && n < 400) begin
            step();
            n++;
        end
        chk(nm, (n < 400) ? 1 : 0, 1);
    endtask

    task automatic chk_cap(string nm);
        chk({nm, "_len"}, cap.size(), exq.size());
        for (int i = 0; i < exq.size() && i < cap.size(); i++)
            chk(nm, cap[i], exq[i]);
        cap.delete();
    endtask

    initial begin
        m_reset();
        #2;
        do_reset();

        // Single vector, read stalled briefly to inspect a_in_0 while idle.
        hold = 1;
        wq = '{8'd1, 8'd2, 8'd3, 8'd4};
        repeat (4) step();
`ifdef ACT_BUF_ZERO_PAD_EN
        chk("pad_between_reads", a_in_0, 0);
`else
        chk("a_in_0_idle_head", a_in_0, 1);
`endif
        hold = 0;
        run_until_idle("single_done");
        exq = '{8'd1, 8'd2, 8'd3, 8'd4};
        chk_cap("single");
        chk("single_full", bank_full, 0);

        // Ping-pong: both banks filled while reads are stalled.
        hold = 1;
        wq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        repeat (10) step();
        chk("pp_wr_ready", wr_ready, 0);
        chk("pp_full", bank_full, 3);
        hold = 0;
        run_until_idle("pp_done");
        exq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        chk_cap("pingpong");

        // Second vector written while the first streams.
        wq = '{8'd1, 8'd2, 8'd3, 8'd4};
        repeat (5) step();
        wq = '{8'd9, 8'd10, 8'd11, 8'd12};
        run_until_idle("overlap_done");
        exq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd11, 8'd12};
        chk_cap("overlap");

        // Stray read while idle.
        force_rd = 1;
        step();
        force_rd = 0;
        step();
        chk("stray_underrun", underrun, 1);
        wq = '{8'd5, 8'd6, 8'd7, 8'd8};
        run_until_idle("stray_done");
        exq = '{8'd5, 8'd6, 8'd7, 8'd8};
        chk_cap("after_stray");
        chk("underrun_sticky", underrun, 1);

        // Reset in the middle of a stream.
        wq = '{8'd1, 8'd2, 8'd3, 8'd4};
        begin
            int n = 0;
            while (cap.size() < 2 && n < 100) begin
                step();
                n++;
            end
            chk("midstream_reached", (n < 100) ? 1 : 0, 1);
        end
        do_reset();
        wq = '{8'd7, 8'd7, 8'd7, 8'd7};
        run_until_idle("post_rst_done");
        exq = '{8'd7, 8'd7, 8'd7, 8'd7};
        chk_cap("post_rst");

        // Randomised traffic with gaps, stalls and stray reads.
        nogap = 0;
        stray_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if (wq.size() < 3 && ($urandom % 3 == 0)) wq.push_back(DW'($urandom));
            hold = ($urandom % 8 == 0);
            step();
        end
        hold = 0;
        stray_en = 0;
        while (wq.size() % N != 0) wq.push_back(DW'($urandom));
        run_until_idle("random_done");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
